// File: rtl/fft8_stage.sv
// One radix-2 DIF stage of the 8-point FFT: load a frame, run four in-place butterflies, drain it.
// Define FFT8_STAGE_SCALE_EN to halve the sum/difference terms (1/2 gain per stage, no overflow).
module fft8_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGE      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_imag,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] cm_a_real,
  output logic [DATA_WIDTH-1:0] cm_a_imag,
  output logic [DATA_WIDTH-1:0] cm_b_real,
  output logic [DATA_WIDTH-1:0] cm_b_imag,
  input  logic [DATA_WIDTH-1:0] cm_y_real,
  input  logic [DATA_WIDTH-1:0] cm_y_imag
);

  localparam int H = 4 >> STAGE;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] p_q, p_d;

  logic [DATA_WIDTH-1:0] bufReal_q [8];
  logic [DATA_WIDTH-1:0] bufImag_q [8];

  logic inFire;
  logic outFire;

  logic [2:0] idxI;
  logic [2:0] idxJ;
  logic [1:0] twK;

  logic [DATA_WIDTH-1:0] aReal, aImag, bReal, bImag;
  logic [DATA_WIDTH:0]   sumReal, sumImag, difReal, difImag;
  logic [DATA_WIDTH-1:0] topReal, topImag, dReal, dImag;
  logic [DATA_WIDTH-1:0] twReal, twImag;

  assign inFire  = in_valid && (state_q == LOAD);
  assign outFire = out_ready && (state_q == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      LOAD: begin
        if (inFire) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = CALC;
            p_d     = 2'd0;
          end
        end
      end
      CALC: begin
        p_d = p_q + 2'd1;
        if (p_q == 2'd3) begin
          state_d = DRAIN;
          cnt_d   = 3'd0;
        end
      end
      DRAIN: begin
        if (outFire) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = LOAD;
            cnt_d   = 3'd0;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = 3'd0;
        p_d     = 2'd0;
      end
    endcase
  end

  // Butterfly p pairs i with i+H inside each 2H-wide group; the twiddle stride doubles every stage.
  always_comb begin
    idxI = 3'((int'(p_q) / H) * (2 * H) + (int'(p_q) % H));
    idxJ = idxI + 3'(H);
    twK  = 2'((int'(p_q) % H) << STAGE);
  end

  always_comb begin
    aReal   = bufReal_q[idxI];
    aImag   = bufImag_q[idxI];
    bReal   = bufReal_q[idxJ];
    bImag   = bufImag_q[idxJ];
    sumReal = {aReal[DATA_WIDTH-1], aReal} + {bReal[DATA_WIDTH-1], bReal};
    sumImag = {aImag[DATA_WIDTH-1], aImag} + {bImag[DATA_WIDTH-1], bImag};
    difReal = {aReal[DATA_WIDTH-1], aReal} - {bReal[DATA_WIDTH-1], bReal};
    difImag = {aImag[DATA_WIDTH-1], aImag} - {bImag[DATA_WIDTH-1], bImag};
  end

`ifdef FFT8_STAGE_SCALE_EN
  logic unusedLsbs;
  assign topReal    = sumReal[DATA_WIDTH:1];
  assign topImag    = sumImag[DATA_WIDTH:1];
  assign dReal      = difReal[DATA_WIDTH:1];
  assign dImag      = difImag[DATA_WIDTH:1];
  assign unusedLsbs = ^{sumReal[0], sumImag[0], difReal[0], difImag[0]};
`else
  logic unusedMsbs;
  assign topReal    = sumReal[DATA_WIDTH-1:0];
  assign topImag    = sumImag[DATA_WIDTH-1:0];
  assign dReal      = difReal[DATA_WIDTH-1:0];
  assign dImag      = difImag[DATA_WIDTH-1:0];
  assign unusedMsbs = ^{sumReal[DATA_WIDTH], sumImag[DATA_WIDTH],
                        difReal[DATA_WIDTH], difImag[DATA_WIDTH]};
`endif

  // W^k = exp(-j*2*pi*k/8) in Q8.8.
  always_comb begin
    twReal = '0;
    twImag = '0;
    unique case (twK)
      2'd0: begin twReal = DATA_WIDTH'(256);  twImag = DATA_WIDTH'(0);    end
      2'd1: begin twReal = DATA_WIDTH'(181);  twImag = DATA_WIDTH'(-181); end
      2'd2: begin twReal = DATA_WIDTH'(0);    twImag = DATA_WIDTH'(-256); end
      default: begin twReal = DATA_WIDTH'(-181); twImag = DATA_WIDTH'(-181); end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == DRAIN);
    out_last  = (state_q == DRAIN) && (cnt_q == 3'd7);
    out_real  = '0;
    out_imag  = '0;
    cm_a_real = '0;
    cm_a_imag = '0;
    cm_b_real = '0;
    cm_b_imag = '0;
    if (state_q == DRAIN) begin
      out_real = bufReal_q[cnt_q];
      out_imag = bufImag_q[cnt_q];
    end
    if (state_q == CALC) begin
      cm_a_real = dReal;
      cm_a_imag = dImag;
      cm_b_real = twReal;
      cm_b_imag = twImag;
    end
  end

  // The frame buffer is deliberately left unreset; a fresh frame overwrites every entry before use.
  always_ff @(posedge clk) begin
    if (inFire) begin
      bufReal_q[cnt_q] <= in_real;
      bufImag_q[cnt_q] <= in_imag;
    end else if (state_q == CALC) begin
      bufReal_q[idxI] <= topReal;
      bufImag_q[idxI] <= topImag;
      bufReal_q[idxJ] <= cm_y_real;
      bufImag_q[idxJ] <= cm_y_imag;
    end
  end

endmodule

// File: tb/tb_fft8_stage.sv
// Randomized self-checking bench for fft8_stage: one instance per STAGE, each with its own
// Q8.8 complex multiplier, compared against a DFT-style reference model of a single DIF stage.
module tb_fft8_stage;

  localparam int DW = 16;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst_n;

  logic          inValid  [3];
  logic          inReady  [3];
  logic          outValid [3];
  logic          outReady [3];
  logic          outLast  [3];
  logic [DW-1:0] inReal   [3];
  logic [DW-1:0] inImag   [3];
  logic [DW-1:0] outReal  [3];
  logic [DW-1:0] outImag  [3];
  logic [DW-1:0] cmAReal  [3];
  logic [DW-1:0] cmAImag  [3];
  logic [DW-1:0] cmBReal  [3];
  logic [DW-1:0] cmBImag  [3];
  logic [DW-1:0] cmYReal  [3];
  logic [DW-1:0] cmYImag  [3];

  int checks   = 0;
  int failures = 0;

  int frameR [8];
  int frameI [8];
  int expR   [8];
  int expI   [8];

  always #5 clk = ~clk;

  function automatic int wrap16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  function automatic int qmulRe(input int ar, input int ai, input int br, input int bi);
    return wrap16((ar * br - ai * bi) >>> 8);
  endfunction

  function automatic int qmulIm(input int ar, input int ai, input int br, input int bi);
    return wrap16((ar * bi + ai * br) >>> 8);
  endfunction

  for (genvar s = 0; s < 3; s++) begin : gStage
    fft8_stage #(.DATA_WIDTH(DW), .STAGE(s)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid[s]),
      .in_ready  (inReady[s]),
      .in_real   (inReal[s]),
      .in_imag   (inImag[s]),
      .out_valid (outValid[s]),
      .out_ready (outReady[s]),
      .out_real  (outReal[s]),
      .out_imag  (outImag[s]),
      .out_last  (outLast[s]),
      .cm_a_real (cmAReal[s]),
      .cm_a_imag (cmAImag[s]),
      .cm_b_real (cmBReal[s]),
      .cm_b_imag (cmBImag[s]),
      .cm_y_real (cmYReal[s]),
      .cm_y_imag (cmYImag[s])
    );
    assign cmYReal[s] = 16'(qmulRe(int'($signed(cmAReal[s])), int'($signed(cmAImag[s])),
                                   int'($signed(cmBReal[s])), int'($signed(cmBImag[s]))));
    assign cmYImag[s] = 16'(qmulIm(int'($signed(cmAReal[s])), int'($signed(cmAImag[s])),
                                   int'($signed(cmBReal[s])), int'($signed(cmBImag[s]))));
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int roundQ(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Reference: for every lower-half index n of each 2H group, out[n] = x[n]+x[n+H] and
  // out[n+H] = (x[n]-x[n+H]) * exp(-j*2*pi*k/8) with k = (n mod H) * 2^stage.
  function automatic void stageModel(input int st);
    int  h, k, ar, ai, br, bi, sr, si, dr, di, wr, wi;
    real ang;
    h = 4 >> st;
    for (int n = 0; n < 8; n++) begin
      if ((n % (2 * h)) >= h) continue;
      k   = (n % h) * (1 << st);
      ang = 2.0 * PI * k / 8.0;
      wr  = roundQ(256.0 * $cos(ang));
      wi  = roundQ(-256.0 * $sin(ang));
      ar  = frameR[n];     ai = frameI[n];
      br  = frameR[n + h]; bi = frameI[n + h];
      sr  = ar + br; si = ai + bi;
      dr  = ar - br; di = ai - bi;
`ifdef FFT8_STAGE_SCALE_EN
      sr = sr >>> 1; si = si >>> 1;
      dr = dr >>> 1; di = di >>> 1;
`endif
      expR[n] = wrap16(sr);
      expI[n] = wrap16(si);
      dr = wrap16(dr);
      di = wrap16(di);
      expR[n + h] = qmulRe(dr, di, wr, wi);
      expI[n + h] = qmulIm(dr, di, wr, wi);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearFrame();
    for (int n = 0; n < 8; n++) begin
      frameR[n] = 0;
      frameI[n] = 0;
    end
  endtask

  task automatic randomFrame();
    for (int n = 0; n < 8; n++) begin
      frameR[n] = wrap16(int'($urandom));
      frameI[n] = wrap16(int'($urandom));
    end
  endtask

  task automatic checkDrainSample(input int st, input int idx);
    checkOutput($sformatf("s%0d_out_valid[%0d]", st, idx), int'(outValid[st]), 1);
    checkOutput($sformatf("s%0d_out_real[%0d]", st, idx), int'($signed(outReal[st])), expR[idx]);
    checkOutput($sformatf("s%0d_out_imag[%0d]", st, idx), int'($signed(outImag[st])), expI[idx]);
    checkOutput($sformatf("s%0d_out_last[%0d]", st, idx), int'(outLast[st]), (idx == 7) ? 1 : 0);
    checkOutput($sformatf("s%0d_cm_a_idle[%0d]", st, idx), int'(cmAReal[st]) | int'(cmBReal[st]), 0);
  endtask

  // Push one frame into a stage, watch CALC, then drain and compare against the model.
  task automatic applyStimulus(input int st, input bit stallIn, input bit stallOut,
                               input bit backPressure, input bit calcProbe, input bit abortAt4);
    int idx, lat, guard;
    stageModel(st);
    for (int n = 0; n < 8; n++) begin
      if (stallIn) repeat ($urandom_range(0, 2)) tick();
      inValid[st] = 1'b1;
      inReal[st]  = 16'(frameR[n]);
      inImag[st]  = 16'(frameI[n]);
      checkOutput($sformatf("s%0d_in_ready_load[%0d]", st, n), int'(inReady[st]), 1);
      tick();
      inValid[st] = 1'b0;
    end
    lat = 0;
    while (!outValid[st] && lat < 20) begin
      checkOutput($sformatf("s%0d_in_ready_calc", st), int'(inReady[st]), 0);
      if (calcProbe && lat == 1) begin
        checkOutput("calc_p1_cm_a_real", int'($signed(cmAReal[st])), 0);
        checkOutput("calc_p1_cm_a_imag", int'($signed(cmAImag[st])), 256);
        checkOutput("calc_p1_cm_b_real", int'($signed(cmBReal[st])), 0);
        checkOutput("calc_p1_cm_b_imag", int'($signed(cmBImag[st])), -256);
      end
      tick();
      lat++;
    end
    checkOutput($sformatf("s%0d_calc_latency", st), lat, 4);
    idx   = 0;
    guard = 0;
    while (idx < 8 && guard < 100) begin
      guard++;
      checkDrainSample(st, idx);
      if (abortAt4 && idx == 4) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", int'(outValid[st]), 0);
        checkOutput("abort_in_ready", int'(inReady[st]), 1);
        outReady[st] = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      if (backPressure && idx == 3) begin
        outReady[st] = 1'b0;
        inValid[st]  = 1'b1;
        inReal[st]   = 16'($urandom);
        inImag[st]   = 16'($urandom);
        repeat (5) begin
          tick();
          checkDrainSample(st, idx);
          checkOutput("bp_in_ready", int'(inReady[st]), 0);
        end
        inValid[st] = 1'b0;
      end
      outReady[st] = stallOut ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (outReady[st]) idx++;
    end
    outReady[st] = 1'b0;
    checkOutput($sformatf("s%0d_drain_done", st), idx, 8);
    checkOutput($sformatf("s%0d_post_out_valid", st), int'(outValid[st]), 0);
    checkOutput($sformatf("s%0d_post_in_ready", st), int'(inReady[st]), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      inValid[s]  = 1'b0;
      outReady[s] = 1'b0;
      inReal[s]   = '0;
      inImag[s]   = '0;
    end
    repeat (3) tick();
    for (int s = 0; s < 3; s++) begin
      checkOutput($sformatf("s%0d_rst_in_ready", s), int'(inReady[s]), 1);
      checkOutput($sformatf("s%0d_rst_out_valid", s), int'(outValid[s]), 0);
      checkOutput($sformatf("s%0d_rst_out_last", s), int'(outLast[s]), 0);
      checkOutput($sformatf("s%0d_rst_cm_a", s), int'({cmAReal[s], cmAImag[s]}), 0);
      checkOutput($sformatf("s%0d_rst_cm_b", s), int'({cmBReal[s], cmBImag[s]}), 0);
    end
    rst_n = 1'b1;
    tick();

    $display("[TB] directed impulse frames");
    clearFrame(); frameR[0] = 256;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clearFrame(); frameR[1] = 256;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clearFrame(); frameR[0] = 32767; frameR[1] = 32767;
    applyStimulus(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clearFrame(); frameI[1] = 256;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] output backpressure");
    randomFrame();
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    clearFrame(); frameR[2] = 256; frameI[6] = -100;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized frames");
    for (int t = 0; t < 9; t++) begin
      randomFrame();
      applyStimulus(t % 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] reset during drain");
    randomFrame();
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    clearFrame(); frameR[0] = 256;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
